ins_fetch_queue: RTL

- Instruction fetch unit: owns the PC, requests 32-bit instruction words from the memory controller and buffers them with their PC in a small FIFO.
- Presents the FIFO head to the decode/issue stage through a valid/ready handshake.
- Accepts a redirect (branch mispredict / jump resolution) that flushes the queue and any in-flight fetch.

---
 rtl/ins_fetch_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ins_fetch_queue.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time, and buffers fetched words with their PC.
// Optional static JAL target prediction is enabled with `define STATIC_JAL_PREDICT_EN.
module ins_fetch_queue #(
   parameter int          QUEUE_DEPTH_LOG = 2,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   output logic        out_valid,
   output logic [31:0] out_ins,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
   localparam logic [QUEUE_DEPTH_LOG-1:0] PTR_ONE = QUEUE_DEPTH_LOG'(1);
   localparam logic [QUEUE_DEPTH_LOG:0]   CNT_ONE = (QUEUE_DEPTH_LOG + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DISCARD
   } state_t;

   state_t                r_state, w_state_next;
   logic [31:0]           r_pc, w_pc_next;
   logic                  r_mem_req, w_mem_req_next;
   logic [31:0]           r_mem_addr, w_mem_addr_next;
   logic [QUEUE_DEPTH_LOG-1:0] r_head, r_tail;
   logic [QUEUE_DEPTH_LOG:0]   r_count;
   logic [31:0]           r_fifo_ins [DEPTH];
   logic [31:0]           r_fifo_pc  [DEPTH];

   logic                  w_push, w_pop, w_full;
   logic [31:0]           w_redirect_pc;
   logic [31:0]           w_seq_pc;
   logic                  w_unused_bits;

   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
   assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

`ifdef STATIC_JAL_PREDICT_EN
   logic        w_is_jal;
   logic [31:0] w_jal_imm;
   assign w_is_jal  = (mem_data[6:0] == 7'b1101111);
   assign w_jal_imm = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                       mem_data[20], mem_data[30:21], 1'b0};
   assign w_seq_pc  = w_is_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);
`else
   assign w_seq_pc  = r_pc + 32'd4;
`endif

   // Count never exceeds DEPTH, so its MSB alone marks a full queue.
   assign w_full    = r_count[QUEUE_DEPTH_LOG];
   assign out_valid = (r_count != '0);
   assign out_ins   = r_fifo_ins[r_head];
   assign out_pc    = r_fifo_pc[r_head];
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;

   // A redirect flushes the queue, so a pop in the same cycle is meaningless.
   assign w_pop = out_valid && out_ready && !redirect;

   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_mem_req_next  = r_mem_req;
      w_mem_addr_next = r_mem_addr;
      w_push          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (redirect) begin
               w_pc_next = w_redirect_pc;
            end else if (!w_full) begin
               w_mem_req_next  = 1'b1;
               w_mem_addr_next = r_pc;
               w_state_next    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               w_pc_next = w_redirect_pc;
               if (mem_done) begin
                  w_mem_req_next = 1'b0;
                  w_state_next   = ST_IDLE;
               end else begin
                  w_state_next   = ST_DISCARD;
               end
            end else if (mem_done) begin
               w_push         = 1'b1;
               w_pc_next      = w_seq_pc;
               w_mem_req_next = 1'b0;
               w_state_next   = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            if (redirect) begin
               w_pc_next = w_redirect_pc;
            end
            if (mem_done) begin
               w_mem_req_next = 1'b0;
               w_state_next   = ST_IDLE;
            end
         end
         default: begin
            w_state_next   = ST_IDLE;
            w_mem_req_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC;
         r_mem_req  <= 1'b0;
         r_mem_addr <= 32'h0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else if (rdy_in) begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_mem_req  <= w_mem_req_next;
         r_mem_addr <= w_mem_addr_next;
         if (redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_tail <= r_tail + PTR_ONE;
            if (w_pop)  r_head <= r_head + PTR_ONE;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_ONE;
               2'b01:   r_count <= r_count - CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Storage has no reset; entries are only observed while counted as valid.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && w_push) begin
         r_fifo_ins[r_tail] <= mem_data;
         r_fifo_pc[r_tail]  <= r_pc;
      end
   end

endmodule
